// File: rtl/rom_read_arbiter.sv
// Two-requester arbiter in front of a single synchronous ROM port. A has priority,
// and B is forced through after STARVE_MAX consecutive denials. Read data is steered back using a tag pipeline.
module rom_read_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_gnt,
    output logic              a_valid,
    output logic [DATA_W-1:0] a_data,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_gnt,
    output logic              b_valid,
    output logic [DATA_W-1:0] b_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0]       starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0]      last_addr_q, last_addr_d;
    logic [RD_LAT-1:0][1:0] tag_q, tag_d;
    logic                   force_b;

    // Grants are gated by rst_n so that nothing is issued while reset is held.
    always_comb begin
        force_b = (starve_cnt_q == CNT_W'(STARVE_MAX));
        a_gnt   = 1'b0;
        b_gnt   = 1'b0;
        if (rst_n) begin
            if (a_req && (!b_req || !force_b))
                a_gnt = 1'b1;
            else if (b_req)
                b_gnt = 1'b1;
        end
    end

    always_comb begin
        rom_addr = '0;
        if (rst_n) begin
            if (a_gnt)
                rom_addr = a_addr;
            else if (b_gnt)
                rom_addr = b_addr;
            else
                rom_addr = last_addr_q;
        end
        last_addr_d = rom_addr;
    end

    always_comb begin
        starve_cnt_d = '0;
        if (b_req && !b_gnt)
            starve_cnt_d = force_b ? starve_cnt_q : starve_cnt_q + CNT_W'(1);
    end

    always_comb begin
        tag_d    = tag_q;
        tag_d[0] = {a_gnt, b_gnt};
        for (int i = 1; i < RD_LAT; i++)
            tag_d[i] = tag_q[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            last_addr_q  <= '0;
            tag_q        <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            last_addr_q  <= last_addr_d;
            tag_q        <= tag_d;
        end
    end

    assign a_valid = tag_q[RD_LAT-1][1];
    assign b_valid = tag_q[RD_LAT-1][0];
    assign a_data  = rom_data;
    assign b_data  = rom_data;
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter. A reference model predicts the grants, and queues
// score the returned data. The ROM model holds mem[i] = i[7:0].
module tb_rom_read_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, b_req;
    logic [10:0] a_addr, b_addr;
    logic        a_gnt, a_valid, b_gnt, b_valid;
    logic [7:0]  a_data, b_data, rom_data;
    logic [10:0] rom_addr;

    int checks = 0;
    int errors = 0;
    logic [7:0]  a_q[$];
    logic [7:0]  b_q[$];
    int          m_starve = 0;
    logic [10:0] m_last = '0;
    logic        m_tag_a = 1'b0, m_tag_b = 1'b0;
    logic        lg_a, lg_b;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_addr[7:0];

    rom_read_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_valid(a_valid), .a_data(a_data),
        .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt), .b_valid(b_valid), .b_data(b_data),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks one cycle at the negedge, advances the model, and returns 1 time unit after the next posedge.
    task automatic cyc();
        logic        eg_a, eg_b;
        logic [10:0] ea;
        @(negedge clk);
        if (!rst_n) begin
            eg_a = 1'b0; eg_b = 1'b0; ea = '0;
            m_tag_a = 1'b0; m_tag_b = 1'b0;
            a_q.delete(); b_q.delete();
        end else begin
            eg_a = a_req && (!b_req || m_starve < 8);
            eg_b = b_req && !eg_a;
            ea   = eg_a ? a_addr : (eg_b ? b_addr : m_last);
        end
        chk("a_gnt", a_gnt, eg_a);
        chk("b_gnt", b_gnt, eg_b);
        chk("rom_addr", rom_addr, ea);
        chk("starve_cnt", dut.starve_cnt_q, m_starve);
        chk("a_valid", a_valid, m_tag_a);
        chk("b_valid", b_valid, m_tag_b);
        if (a_valid && m_tag_a && a_q.size() > 0) chk("a_data", a_data, a_q.pop_front());
        if (b_valid && m_tag_b && b_q.size() > 0) chk("b_data", b_data, b_q.pop_front());
        if (!rst_n) begin
            m_starve = 0; m_last = '0;
        end else begin
            m_tag_a = eg_a; m_tag_b = eg_b;
            if (eg_a) a_q.push_back(ea[7:0]);
            if (eg_b) b_q.push_back(ea[7:0]);
            m_starve = (b_req && !eg_b) ? ((m_starve < 8) ? m_starve + 1 : 8) : 0;
            m_last = ea;
        end
        lg_a = eg_a; lg_b = eg_b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; a_req = 1'b1; b_req = 1'b1; a_addr = 11'h3C1; b_addr = 11'h1F7;
        #1;
        repeat (3) cyc();

        rst_n = 1'b1; a_req = 1'b0; b_req = 1'b0;
        repeat (2) cyc();

        // A only
        a_req = 1'b1; a_addr = 11'h123;
        cyc();
        a_req = 1'b0;
        repeat (2) cyc();

        // Contention: 8 A grants then a forced B grant, repeating
        a_req = 1'b1; b_req = 1'b1; a_addr = 11'h010; b_addr = 11'h700;
        for (int i = 0; i < 27; i++) begin
            cyc();
            if (lg_a) a_addr = 11'($urandom_range(0, 2047));
            if (lg_b) b_addr = 11'($urandom_range(0, 2047));
        end
        a_req = 1'b0; b_req = 1'b0;
        repeat (2) cyc();

        // B streaming across the full address space
        b_req = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            b_addr = 11'(i);
            cyc();
        end
        b_req = 1'b0;
        repeat (2) cyc();

        // Reset while an A read is in flight
        a_req = 1'b1; a_addr = 11'h055;
        cyc();
        rst_n = 1'b0; a_req = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (3) cyc();

        // Idle hold after a B grant
        b_req = 1'b1; b_addr = 11'h2A5;
        cyc();
        b_req = 1'b0;
        repeat (10) cyc();
        chk("last_addr_hold", rom_addr, 11'h2A5);

        chk("a_q_drained", a_q.size(), 0);
        chk("b_q_drained", b_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rom_read_arbiter.md
# rom_read_arbiter

Shares the single synchronous character/pattern ROM between two read requesters. Requester A is the display pixel-fetch path and is time-critical. Requester B is a secondary reader, such as an overlay or readback engine. The block sits between the requesters and the ROM port. Each cycle it issues at most one address, returns each read to the requester that issued it, and guarantees B a slot within a bounded number of cycles.

## Interface
Parameters:
- ADDR_W, 11, ROM address width
- DATA_W, 8, ROM data width
- RD_LAT, 1, ROM read latency in cycles, from address sampled to data valid; must be ≥1
- STARVE_MAX, 8, consecutive B denials after which B is forced through; must be ≥1

Ports:
- clk  in  1  single system clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_req  in  1  A read request; A holds it with a_addr stable until a_gnt
- a_addr  in  ADDR_W  A read address
- a_gnt  out  1  A request accepted this cycle
- a_valid  out  1  a_data holds A's read result this cycle
- a_data  out  DATA_W  A read data
- b_req  in  1  B read request; same hold rule as A
- b_addr  in  ADDR_W  B read address
- b_gnt  out  1  B request accepted this cycle
- b_valid  out  1  b_data holds B's read result this cycle
- b_data  out  DATA_W  B read data
- rom_addr  out  ADDR_W  address to the ROM port
- rom_data  in  DATA_W  ROM read data

## Operation
- Arbitration is decided combinationally each cycle from a_req, b_req and the starve counter. The ROM samples rom_addr at the end of the grant cycle.
- Grant rules:
  - Neither requests: no grant.
  - Only A requests: A wins.
  - Only B requests: B wins.
  - Both request and starve_cnt < STARVE_MAX: A wins.
  - Both request and starve_cnt == STARVE_MAX: B wins (forced slot).
- At most one of a_gnt and b_gnt is high in any cycle.
- rom_addr:
  - Equals the winner's address in a grant cycle.
  - Otherwise equals the last issued address, held in a register (last_addr).
- starve_cnt:
  - Width $clog2(STARVE_MAX+1).
  - Increments (saturating at STARVE_MAX) when b_req=1 and b_gnt=0.
  - Clears to 0 when b_gnt=1 or b_req=0.
- Return path: a tag pipeline RD_LAT stages deep.
  - Stage 0 is loaded with {a_gnt, b_gnt} each cycle.
  - Stage RD_LAT-1 drives a_valid and b_valid.
  - a_data and b_data both pass rom_data through. They are only meaningful while the matching valid is high.
- There is no backpressure on the return path. Requesters must accept data whenever valid is high.
- Read results return in grant order. Back-to-back grants give one result per cycle.

## Timing
- Reset (rst_n=0, asynchronous):
  - starve_cnt=0, last_addr=0, all tag stages=0.
  - a_gnt=0, b_gnt=0, a_valid=0, b_valid=0, rom_addr=0, regardless of a_req and b_req.
  - a_data and b_data follow rom_data (don't-care).
- Grant latency is 0 cycles: gnt rises in the same cycle as req when the requester wins.
- Read latency: valid rises exactly RD_LAT cycles after the grant cycle and lasts one cycle per grant.
- Under continuous requests from both, the pattern is STARVE_MAX A grants, then 1 B grant, repeating. A therefore sees at most 1 stall per STARVE_MAX+1 cycles.
- Reset mid-operation: in-flight tags are discarded. No valid is produced after rst_n rises for any grant made before reset.
- First grant after reset release: the cycle in which rst_n is sampled high and a req is present.

## Test plan
- Reset: hold rst_n=0 with a_req=b_req=1 → a_gnt, b_gnt, a_valid, b_valid all 0 and rom_addr=0x000 throughout.
- A only: a_addr=0x123 for one cycle (ROM loaded with mem[i]=i[7:0]) → a_gnt=1 in the same cycle, rom_addr=0x123, a_valid=1 with a_data=0x23 one cycle later (RD_LAT=1), b_valid never 1.
- Contention: a_req=b_req=1 continuously, STARVE_MAX=8 → a_gnt in cycles 0–7, b_gnt in cycle 8, then repeat. starve_cnt reads 0..8 then 0. Every grant produces exactly one valid on the matching side.
- B streaming: b_req=1 alone, b_addr stepping 0x000→0x7FF → b_gnt every cycle, 2048 b_valid pulses in address order with b_data=addr[7:0].
- Reset in flight: a_gnt in cycle N, rst_n=0 in cycle N+1 for 2 cycles → no a_valid is ever produced for that grant, and starve_cnt=0 after release.
- Idle hold: grant B at 0x2A5, then both req=0 for 10 cycles → rom_addr stays 0x2A5, no gnt and no valid.
